output_formatter: RTL
=====================

// Module: output_formatter
// PURPOSE
//  Transmit-side counterpart of the calculator input parser.
//  Takes a 16-bit ALU result (or error flag) and converts it to ASCII decimal.
//  Writes it byte-by-byte into the UART TX FIFO, MSB digit first, leading zeros suppressed.
//  Sits between the ALU result register and the TX FIFO write port.
// PARAMETERS
//  DATA_WIDTH    8    FIFO byte width; ASCII in bits [7:0], upper bits zero
//  RESULT_WIDTH  16   result width; only 16 supported (5 BCD digits)
// PORTS
//  clk            in   1             single clock, all logic on posedge
//  rst            in   1             asynchronous, active-high reset
//  result_in      in   RESULT_WIDTH  unsigned ALU result
//  err_in         in   1             result invalid (e.g. divide by zero); sampled with result_valid_in
//  result_valid_in in  1             1-cycle strobe: result_in/err_in valid
//  tx_full_in     in   1             TX FIFO full
//  tx_wen_o       out  1             TX FIFO write enable
//  tx_data_o      out  DATA_WIDTH    byte to write
//  busy_o         out  1             conversion/emission in progress
//  done_o         out  1             1-cycle pulse after last byte written
// BEHAVIOUR
//  Reset: state=IDLE; tx_wen_o=0, tx_data_o=0, busy_o=0, done_o=0, internal BCD/shift/counters=0.
//   Reset mid-operation aborts immediately; the partial string is not completed.
//  FSM: IDLE -> CONVERT -> EMIT -> (TERM) -> DONE -> IDLE.
//  IDLE:
//   - result_valid_in sampled only here; strobes in any other state are ignored (no queue).
//   - On strobe at cycle T: latch result_in/err_in; busy_o=1 from T+1.
//   - err_in=1 skips CONVERT; goes to EMIT with the fixed string "ERR" (0x45,0x52,0x52).
//  CONVERT:
//   - Double-dabble: 16 iterations, one per cycle (T+1..T+16).
//   - Each cycle: add 3 to every BCD nibble >=5, then shift {bcd[19:0],bin[15:0]} left 1.
//   - 5-bit iteration counter; exit to EMIT after 16th shift.
//  EMIT:
//   - Digit index starts at the most significant nonzero nibble.
//   - Value 0 emits exactly one '0'.
//   - Byte = 8'h30 + nibble.
//   - Write rule: tx_wen_o=1 iff a byte is pending and tx_full_in=0 in the same cycle (combinational gate).
//   - Index advances only on a cycle with tx_wen_o=1.
//   - tx_full_in=1 holds the index and tx_data_o; no byte is lost or duplicated.
//   - Max 1 byte/cycle; first write no earlier than T+17 (numeric) or T+1 (error).
//  DONE: done_o=1 for exactly one cycle, tx_wen_o=0; next cycle IDLE with busy_o=0.
//   A new strobe is accepted in that IDLE cycle.
//  tx_data_o upper bits [DATA_WIDTH-1:8] always 0.
//  tx_data_o holds its last value when tx_wen_o=0.
// CONFIGURATION
//  TX_CRLF_EN defined:
//   - After the payload (digits or "ERR"), TERM state writes 0x0D then 0x0A under the same full/wen rules.
//   - Then DONE.
//  TX_CRLF_EN undefined:
//   - TERM state not built; EMIT goes directly to DONE after the last payload byte.
// TESTING
//  1. result=12345, tx_full=0 -> bytes 31 32 33 34 35 on consecutive cycles T+17..T+21; done_o at T+22 (+0D 0A before done if TX_CRLF_EN).
//  2. result=0 -> single byte 0x30; result=65535 -> 36 35 35 33 35; result=700 -> 37 30 30 (inner zeros kept).
//  3. result=7, tx_full_in high for 5 cycles from T+17 -> no tx_wen_o while full; exactly one 0x37 written after release.
//  4. err_in=1 with result=1234 -> 45 52 52 starting T+1; no digits emitted.
//  5. Second result_valid_in pulsed while busy_o=1 -> ignored; only the first result is emitted; strobe in the IDLE cycle after done_o is accepted.
//  6. rst asserted during EMIT after 2 of 5 bytes -> outputs 0 next edge; FSM idle; next strobe emits a complete fresh string.

Source files
------------

// File: rtl/output_formatter.sv
// Converts a 16-bit result (or error flag) to ASCII decimal and writes it byte-by-byte into a TX FIFO.
// Define TX_CRLF_EN to append a CR/LF terminator after every payload string.
module output_formatter #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESULT_WIDTH-1:0] result_in,
    input  logic                    err_in,
    input  logic                    result_valid_in,
    input  logic                    tx_full_in,
    output logic                    tx_wen_o,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_EMIT    = 3'd2;
`ifdef TX_CRLF_EN
    localparam logic [2:0] S_TERM    = 3'd3;
`endif
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]  state;
    logic [35:0] shift_q;     // {bcd[19:0], bin[15:0]}
    logic [4:0]  cnt_q;
    logic [2:0]  idx_q;       // digit index, 4 = most significant
    logic        err_q;
    logic [7:0]  last_q;
`ifdef TX_CRLF_EN
    logic        lf_q;        // 0: CR pending, 1: LF pending
`endif

    logic [19:0] adj_bcd;
    logic [35:0] shift_next;
    logic [19:0] bcd_next;
    logic [2:0]  msd_next;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;
    logic        pending;

    // Double-dabble step: add 3 to each nibble >= 5, then shift the whole register left.
    always_comb begin
        adj_bcd = '0;
        for (int i = 0; i < 5; i++) begin
            if (shift_q[16+4*i +: 4] >= 4'd5)
                adj_bcd[4*i +: 4] = shift_q[16+4*i +: 4] + 4'd3;
            else
                adj_bcd[4*i +: 4] = shift_q[16+4*i +: 4];
        end
        shift_next = {adj_bcd, shift_q[15:0]} << 1;
        bcd_next   = shift_next[35:16];
    end

    always_comb begin
        if (bcd_next[19:16] != 4'd0)
            msd_next = 3'd4;
        else if (bcd_next[15:12] != 4'd0)
            msd_next = 3'd3;
        else if (bcd_next[11:8] != 4'd0)
            msd_next = 3'd2;
        else if (bcd_next[7:4] != 4'd0)
            msd_next = 3'd1;
        else
            msd_next = 3'd0;
    end

    always_comb begin
        case (idx_q)
            3'd4:    nib = shift_q[35:32];
            3'd3:    nib = shift_q[31:28];
            3'd2:    nib = shift_q[27:24];
            3'd1:    nib = shift_q[23:20];
            default: nib = shift_q[19:16];
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        pending  = 1'b0;
        case (state)
            S_EMIT: begin
                pending = 1'b1;
                if (err_q)
                    cur_byte = (idx_q == 3'd2) ? 8'h45 : 8'h52;
                else
                    cur_byte = {4'h3, nib};
            end
`ifdef TX_CRLF_EN
            S_TERM: begin
                pending  = 1'b1;
                cur_byte = lf_q ? 8'h0A : 8'h0D;
            end
`endif
            default: begin
                cur_byte = 8'h00;
                pending  = 1'b0;
            end
        endcase
    end

    // Write is gated combinationally by FIFO full; data holds the last written byte otherwise.
    assign tx_wen_o = pending && !tx_full_in;
    assign busy_o   = (state != S_IDLE);
    assign done_o   = (state == S_DONE);

    always_comb begin
        tx_data_o      = '0;
        tx_data_o[7:0] = tx_wen_o ? cur_byte : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= '0;
`ifdef TX_CRLF_EN
            lf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (result_valid_in) begin
                        err_q   <= err_in;
                        shift_q <= {20'd0, result_in[15:0]};
                        cnt_q   <= '0;
                        if (err_in) begin
                            idx_q <= 3'd2;
                            state <= S_EMIT;
                        end else begin
                            state <= S_CONVERT;
                        end
                    end
                end
                S_CONVERT: begin
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        cnt_q <= '0;
                        idx_q <= msd_next;
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tx_wen_o) begin
                        last_q <= cur_byte;
                        if (idx_q == 3'd0) begin
`ifdef TX_CRLF_EN
                            lf_q  <= 1'b0;
                            state <= S_TERM;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            idx_q <= idx_q - 3'd1;
                        end
                    end
                end
`ifdef TX_CRLF_EN
                S_TERM: begin
                    if (tx_wen_o) begin
                        last_q <= cur_byte;
                        if (lf_q)
                            state <= S_DONE;
                        else
                            lf_q <= 1'b1;
                    end
                end
`endif
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
